// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
//   state_t  : controller states (IDLE, FILL, WRITE)
//   idx_bits : number of index bits for a given (power-of-two) set count
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // log2 of a power-of-two set count
  function automatic int idx_bits(input int sets);
    int n;
    n = 0;
    while ((1 << n) < sets) n++;
    return n;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line valid bit, tag and data word for the direct-mapped cache.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valid bits only)
//   rd_idx            combinational read index
//   rd_valid/tag/data line contents at rd_idx
//   we                write strobe: sets valid and stores wr_tag / wr_data at wr_idx
module dcache_array #(
  parameter int SETS       = 16,
  parameter int IDX        = 4,
  parameter int TAG_W      = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX-1:0]        rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic [IDX-1:0]        wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tags  [SETS];
  logic [DATA_WIDTH-1:0] words [SETS];

  // valid bits: cleared by reset, set on any line write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= {SETS{1'b0}};
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // tag and data storage; no reset needed since valid gates their use
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// Core side : req_valid/req_we/req_addr/req_wdata in, resp_rdata and stall out.
//             Read hits return data in the same cycle; misses and all stores stall.
// Memory side: mem_req/mem_we/mem_addr/mem_wdata out (registered, held until
//             mem_ready), mem_rdata/mem_ready in (ready is a one-cycle pulse).
// Optional  : define DCACHE_STATS_EN to add hit_count/miss_count outputs
//             (read hits and read misses, saturating 32-bit counters).
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX   = idx_bits(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  done_q;
  logic [IDX-1:0]        look_idx;
  logic [TAG_W-1:0]      look_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;
  logic                  mem_done;
  logic                  start_fill;
  logic                  start_write;
  logic                  line_we;
  logic                  unused_lsbs;

  // byte offset within the word carries no meaning for word accesses
  assign unused_lsbs = ^req_addr[1:0];

  // IDLE probes with the core address; during a transfer the captured address
  // is used, so a store's tag compare sees the line as it is at completion
  assign look_idx = (state == IDLE) ? req_addr[IDX+1:2] : addr_q[IDX+1:2];
  assign look_tag = (state == IDLE) ? req_addr[ADDR_WIDTH-1:IDX+2]
                                    : addr_q[ADDR_WIDTH-1:IDX+2];
  assign hit      = line_valid && (line_tag == look_tag);
  // a ready pulse only counts while a request is outstanding
  assign mem_done = mem_req && mem_ready;

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = (state == IDLE && req_valid && !req_we && hit)
                      ? line_data : {DATA_WIDTH{1'b0}};

  dcache_array #(
    .SETS       (SETS),
    .IDX        (IDX),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (look_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (line_we),
    .wr_idx   (look_idx),
    .wr_tag   (look_tag),
    .wr_data  ((state == FILL) ? mem_rdata : wdata_q)
  );

  // next-state, stall and line-write decode
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    line_we     = 1'b0;
    case (state)
      IDLE: begin
        // done_q marks the cycle in which the just-written store retires
        if (req_valid && !done_q) begin
          if (req_we) begin
            stall       = 1'b1;
            start_write = 1'b1;
            state_next  = WRITE;
          end else if (!hit) begin
            stall      = 1'b1;
            start_fill = 1'b1;
            state_next = FILL;
          end else begin
            stall = 1'b0;
          end
        end else begin
          stall = 1'b0;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (mem_done) begin
          line_we    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (mem_done) begin
          // write-through: only refresh a line that already holds this address
          line_we    = hit;
          state_next = IDLE;
        end else begin
          state_next = WRITE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // state, captured request and registered memory handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == WRITE) && mem_done;
      if (start_fill || start_write) begin
        mem_req <= 1'b1;
        mem_we  <= start_write;
        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      end else if (mem_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (start_write) begin
        wdata_q <= req_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic fill_done_q;
  logic count_hit;

  // the hit that follows a fill belongs to the already-counted miss
  assign count_hit = (state == IDLE) && req_valid && !req_we && hit
                     && !fill_done_q && !done_q;

  // saturating read hit / miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= (state == FILL) && mem_done;
      if (count_hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_fill && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: self-checking bench for dcache_dm.
// A transaction-level model (per-set valid/tag/data plus a reference memory)
// predicts, for every access, the cycle-by-cycle stall and memory-port values;
// one compare process checks them each cycle on the falling edge.
module tb_dcache_dm;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SETS = 16;
  localparam int IDX  = 4;
  localparam int TW   = AW - IDX - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  always #5 clk = ~clk;

  dcache_dm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // backing store seen by the DUT, and the model's idea of what it should hold
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          lat = 0;

  // model cache
  bit          m_valid [SETS];
  logic [TW-1:0] m_tag [SETS];
  logic [31:0] m_data  [SETS];
  int          m_hits = 0;
  int          m_miss = 0;

  // per-cycle expectations
  bit          chk_en = 1'b0;
  bit          e_stall, e_mreq, e_mwe, e_rd;
  logic [31:0] e_maddr, e_mwdata, e_rdata;
  int          stall_total = 0;
  logic [31:0] last_rdata, last_maddr;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every checked cycle, DUT against the model's expectation
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
      if (e_mreq) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, e_mwe});
        check("mem_addr", mem_addr, e_maddr);
        if (e_mwe) check("mem_wdata", mem_wdata, e_mwdata);
      end
      if (e_rd) check("resp_rdata", resp_rdata, e_rdata);
      stall_total = stall_total + (stall ? 1 : 0);
      last_rdata  = resp_rdata;
      if (mem_req) last_maddr = mem_addr;
    end
  end

  // backing store: answers LAT cycles after the request first appears,
  // and throws stray ready pulses while no request is outstanding
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (cnt == lat) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          cnt++;
        end
      end else begin
        cnt = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  // one core access; called and returns at posedge+1
  task automatic access(input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input int l);
    int            idx;
    logic [TW-1:0] tg;
    logic [31:0]   w;
    bit            hit;
    idx = int'(addr[IDX+1:2]);
    tg  = addr[AW-1:IDX+2];
    w   = {addr[31:2], 2'b00};
    hit = m_valid[idx] && (m_tag[idx] == tg);
    lat = l;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    e_mreq = 1'b0; e_mwe = we; e_maddr = w; e_mwdata = wd;
    if (!we && hit) begin
      m_hits++;
      e_stall = 1'b0; e_rd = 1'b1; e_rdata = m_data[idx];
      @(posedge clk); #1;
    end else begin
      if (!we) m_miss++;
      e_stall = 1'b1; e_rd = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c <= l; c++) begin
        e_mreq = 1'b1;
        @(posedge clk); #1;
      end
      if (we) begin
        ref_mem[w] = wd;
        if (hit) m_data[idx] = wd;
      end else begin
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = ref_read(w);
      end
      e_stall = 1'b0; e_mreq = 1'b0; e_rd = !we; e_rdata = m_data[idx];
      @(posedge clk); #1;
    end
    req_valid = 1'b0; e_rd = 1'b0; e_stall = 1'b0; e_mreq = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  initial begin
    int s0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    e_stall = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0; e_rd = 1'b0;
    e_maddr = 32'd0; e_mwdata = 32'd0; e_rdata = 32'd0;
    model_reset();
    mem[32'h40]     = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // cold read, 3-cycle memory
    s0 = stall_total;
    access(1'b0, 32'h40, 32'd0, 3);
    check("cold_stall_cycles", stall_total - s0, 32'd5);
    check("cold_mem_addr", last_maddr, 32'h40);
    check("cold_rdata", last_rdata, 32'hDEAD_BEEF);
    // repeat read hits
    s0 = stall_total;
    access(1'b0, 32'h40, 32'd0, 3);
    check("hit_stall_cycles", stall_total - s0, 32'd0);
    check("hit_rdata", last_rdata, 32'hDEAD_BEEF);
    // store hit, then read it back
    s0 = stall_total;
    access(1'b1, 32'h40, 32'h1234_5678, 2);
    check("store_stall_cycles", stall_total - s0, 32'd4);
    check("store_mem", mem[32'h40], 32'h1234_5678);
    access(1'b0, 32'h40, 32'd0, 2);
    check("store_readback", last_rdata, 32'h1234_5678);
    // store miss to same index: written through, not allocated
    access(1'b1, 32'h80, 32'hCAFE_F00D, 1);
    s0 = stall_total;
    access(1'b0, 32'h80, 32'd0, 2);
    check("nowa_stall_cycles", stall_total - s0, 32'd4);
    check("nowa_rdata", last_rdata, 32'hCAFE_F00D);
`ifdef DCACHE_STATS_EN
    check("hit_count_lit", hit_count, 32'd2);
    check("miss_count_lit", miss_count, 32'd2);
`endif
    s0 = stall_total;
    access(1'b0, 32'h40, 32'd0, 0);
    check("evict_stall_cycles", stall_total - s0, 32'd2);
    check("evict_rdata", last_rdata, 32'h1234_5678);

    // reset during a fill
    lat = 6;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80;
    e_stall = 1'b1; e_mreq = 1'b0; e_rd = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0; rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1; e_stall = 1'b0; e_mreq = 1'b0;
    model_reset();
    @(negedge clk);
    check("rstfill_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstfill_stall", {31'd0, stall}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    s0 = stall_total;
    access(1'b0, 32'h40, 32'd0, 2);
    check("rstfill_remiss_cycles", stall_total - s0, 32'd4);

    // randomized traffic over a few tags per set
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, SETS - 1) << 2)
          | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_miss);
`endif
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
